// File: rtl/arbiter_pkg.sv
// rtl/arbiter_pkg.sv - shared defaults, polarity encoding and packet layout for the event path
package arbiter_pkg;

  localparam int DEFAULT_ROW_W = 4;
  localparam int DEFAULT_COL_W = 4;
  localparam int DEFAULT_TS_W  = 16;
  localparam int DEFAULT_DEPTH = 8;

  // Value of the pol bit for an ON event; OFF events carry the complement
  localparam logic POLARITY = 1'b1;

  // Packet layout at the default widths, MSB first
  typedef struct packed {
    logic [DEFAULT_TS_W-1:0]  ts;
    logic [DEFAULT_ROW_W-1:0] row;
    logic [DEFAULT_COL_W-1:0] col;
    logic                     pol;
  } packet_t;

endpackage

// File: rtl/event_fifo.sv
// rtl/event_fifo.sv - first-word-fall-through packet buffer with wrapping pointers
module event_fifo
  import arbiter_pkg::*;
#(
  parameter int WIDTH = 25,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  // Flags and head data come straight from registered state (FWFT)
  always_comb begin
    full_o  = (count_q == CW'(DEPTH));
    empty_o = (count_q == '0);
    count_o = count_q;
    rdata_o = mem_q[rd_ptr_q];
    push_ok = push_i && !full_o;
    pop_ok  = pop_i && !empty_o;
  end

  // Next pointer/count; pointers wrap naturally because DEPTH is a power of two
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers; reset empties the buffer
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible once counted
  always_ff @(posedge clk_i) begin
    if (push_ok && !reset_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/event_packetizer.sv
// rtl/event_packetizer.sv - timestamps granted pixel events and buffers them as packets
module event_packetizer
  import arbiter_pkg::*;
#(
  parameter int ROW_W = DEFAULT_ROW_W,
  parameter int COL_W = DEFAULT_COL_W,
  parameter int TS_W  = DEFAULT_TS_W,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          evt_valid_i,
  input  logic [ROW_W-1:0]              row_addr_i,
  input  logic [COL_W-1:0]              col_addr_i,
  input  logic                          pol_i,
  output logic                          evt_ready_o,
  input  logic                          ts_clear_i,
  input  logic                          ovf_clr_i,
  output logic                          pkt_valid_o,
  output logic [TS_W+ROW_W+COL_W:0]     pkt_data_o,
  input  logic                          pkt_ready_i,
  output logic [$clog2(DEPTH):0]        count_o,
  output logic                          overflow_o
);

  localparam int PW = TS_W + ROW_W + COL_W + 1;

  logic [TS_W-1:0] ts_q, ts_d;
  logic            overflow_q, overflow_d;
  logic            fifo_full, fifo_empty;
  logic            push, pop;
  logic [PW-1:0]   pkt_in;

  // Handshakes; ready depends only on the registered fill level
  always_comb begin
    evt_ready_o = !fifo_full;
    pkt_valid_o = !fifo_empty;
    push        = evt_valid_i && evt_ready_o;
    pop         = pkt_valid_o && pkt_ready_i;
    pkt_in      = {ts_q, row_addr_i, col_addr_i, pol_i};
    overflow_o  = overflow_q;
  end

  // Timestamp advance (clear beats increment) and sticky overflow (new overflow beats clear)
  always_comb begin
    ts_d = ts_clear_i ? '0 : ts_q + TS_W'(1);
    overflow_d = overflow_q;
    if (ovf_clr_i) overflow_d = 1'b0;
    if (evt_valid_i && fifo_full) overflow_d = 1'b1;
  end

  // Timestamp and overflow registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ts_q       <= '0;
      overflow_q <= 1'b0;
    end else begin
      ts_q       <= ts_d;
      overflow_q <= overflow_d;
    end
  end

  event_fifo #(
    .WIDTH (PW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (pkt_in),
    .rdata_o (pkt_data_o),
    .count_o (count_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_event_packetizer.sv
// tb/tb_event_packetizer.sv - randomized and directed checks against a queue-based reference
module tb_event_packetizer;
  import arbiter_pkg::*;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        evt_valid_i = 1'b0;
  logic [3:0]  row_addr_i = '0;
  logic [3:0]  col_addr_i = '0;
  logic        pol_i = 1'b0;
  logic        evt_ready_o;
  logic        ts_clear_i = 1'b0;
  logic        ovf_clr_i = 1'b0;
  logic        pkt_valid_o;
  logic [24:0] pkt_data_o;
  logic        pkt_ready_i = 1'b0;
  logic [3:0]  count_o;
  logic        overflow_o;

  int n_chk  = 0;
  int n_fail = 0;

  packet_t mq[$];
  int      m_ts  = 0;
  bit      m_ovf = 1'b0;

  event_packetizer dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .evt_valid_i (evt_valid_i),
    .row_addr_i  (row_addr_i),
    .col_addr_i  (col_addr_i),
    .pol_i       (pol_i),
    .evt_ready_o (evt_ready_o),
    .ts_clear_i  (ts_clear_i),
    .ovf_clr_i   (ovf_clr_i),
    .pkt_valid_o (pkt_valid_o),
    .pkt_data_o  (pkt_data_o),
    .pkt_ready_i (pkt_ready_i),
    .count_o     (count_o),
    .overflow_o  (overflow_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("count", 32'(count_o), 32'(mq.size()));
    chk("pkt_valid", 32'(pkt_valid_o), 32'(mq.size() != 0));
    chk("evt_ready", 32'(evt_ready_o), 32'(mq.size() != DEPTH));
    chk("overflow", 32'(overflow_o), 32'(m_ovf));
    if (mq.size() != 0) chk("pkt_data", 32'(pkt_data_o), 32'(mq[0]));
  endtask

  // One clock: predict from the current inputs, advance, then compare
  task automatic tick();
    bit      m_full, do_push, do_pop;
    packet_t p;
    m_full  = (mq.size() == DEPTH);
    do_push = evt_valid_i && !m_full;
    do_pop  = pkt_ready_i && (mq.size() != 0);
    p.ts  = 16'(m_ts);
    p.row = row_addr_i;
    p.col = col_addr_i;
    p.pol = pol_i;
    @(posedge clk);
    if (reset_i) begin
      mq.delete();
      m_ts  = 0;
      m_ovf = 1'b0;
    end else begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(p);
      m_ts = ts_clear_i ? 0 : (m_ts + 1) % 65536;
      if (evt_valid_i && m_full) m_ovf = 1'b1;
      else if (ovf_clr_i) m_ovf = 1'b0;
    end
    #1;
    check_all();
  endtask

  task automatic idle();
    evt_valid_i = 1'b0; ts_clear_i = 1'b0; ovf_clr_i = 1'b0; pkt_ready_i = 1'b0; reset_i = 1'b0;
  endtask

  task automatic offer(input logic [3:0] r, input logic [3:0] c, input logic p);
    evt_valid_i = 1'b1; row_addr_i = r; col_addr_i = c; pol_i = p;
  endtask

  task automatic drain();
    int guard;
    idle();
    pkt_ready_i = 1'b1;
    guard = 0;
    while (mq.size() != 0 && guard < 20) begin
      tick();
      guard++;
    end
    chk("drain_bound", 32'(mq.size()), 32'd0);
    pkt_ready_i = 1'b0;
  endtask

  task automatic run_to_ts(input int target);
    int guard;
    idle();
    guard = 0;
    while (m_ts != target && guard < 1000) begin
      tick();
      guard++;
    end
    chk("ts_reach_bound", 32'(m_ts), 32'(target));
  endtask

  initial begin
    packet_t exp_p;
    int k;

    // Reset state
    reset_i = 1'b1;
    tick();
    idle();

    // Single event at timestamp 0x0010
    run_to_ts(16'h0010);
    offer(4'd3, 4'd5, POLARITY);
    tick();
    idle();
    exp_p = '{ts: 16'h0010, row: 4'd3, col: 4'd5, pol: 1'b1};
    chk("first_pkt_data", 32'(pkt_data_o), 32'(exp_p));
    chk("first_pkt_count", 32'(count_o), 32'd1);
    drain();

    // Fill to full, overflow on the ninth offer, overflow clear rules
    for (int i = 0; i < DEPTH; i++) begin
      offer(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      tick();
    end
    chk("full_count", 32'(count_o), 32'd8);
    chk("full_ready", 32'(evt_ready_o), 32'd0);
    offer(4'hF, 4'hF, 1'b0);
    tick();
    chk("ovf_set", 32'(overflow_o), 32'd1);
    ovf_clr_i = 1'b1;
    tick();
    chk("ovf_clr_loses", 32'(overflow_o), 32'd1);
    evt_valid_i = 1'b0;
    tick();
    chk("ovf_cleared", 32'(overflow_o), 32'd0);

    // Full with pop and push in the same cycle: pop only
    idle();
    pkt_ready_i = 1'b1;
    offer(4'd1, 4'd2, 1'b1);
    tick();
    chk("full_pop_count", 32'(count_o), 32'd7);
    chk("full_pop_ready", 32'(evt_ready_o), 32'd1);
    drain();

    // Timestamp clear coinciding with a push
    ts_clear_i = 1'b1;
    tick();
    run_to_ts(16'h0123);
    offer(4'd7, 4'd8, 1'b0);
    ts_clear_i = 1'b1;
    tick();
    ts_clear_i = 1'b0;
    offer(4'd9, 4'd10, 1'b1);
    tick();
    idle();
    chk("tsclr_pre_value", 32'(pkt_data_o[24:9]), 32'h0123);
    pkt_ready_i = 1'b1;
    tick();
    chk("tsclr_post_value", 32'(pkt_data_o[24:9]), 32'h0000);
    drain();

    // Timestamp wrap: jump to 0xFFFF without per-cycle checks
    idle();
    k = (16'hFFFF - m_ts) & 16'hFFFF;
    repeat (k) @(posedge clk);
    #1;
    m_ts = 16'hFFFF;
    offer(4'd4, 4'd4, 1'b1);
    tick();
    offer(4'd6, 4'd6, 1'b0);
    tick();
    idle();
    chk("wrap_ts_ffff", 32'(pkt_data_o[24:9]), 32'hFFFF);
    pkt_ready_i = 1'b1;
    tick();
    chk("wrap_ts_0000", 32'(pkt_data_o[24:9]), 32'h0000);
    drain();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      evt_valid_i = ($urandom_range(0, 9) < 6);
      row_addr_i  = 4'($urandom_range(0, 15));
      col_addr_i  = 4'($urandom_range(0, 15));
      pol_i       = 1'($urandom_range(0, 1));
      pkt_ready_i = ($urandom_range(0, 9) < 5);
      ts_clear_i  = ($urandom_range(0, 31) == 0);
      ovf_clr_i   = ($urandom_range(0, 7) == 0);
      tick();
    end
    drain();

    // Reset with three buffered packets
    idle();
    for (int i = 0; i < 3; i++) begin
      offer(4'(i), 4'(i + 1), 1'b1);
      tick();
    end
    idle();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_valid", 32'(pkt_valid_o), 32'd0);
    chk("rst_ready", 32'(evt_ready_o), 32'd1);
    chk("rst_ovf", 32'(overflow_o), 32'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
